// File: rtl/spi_burst_sensor_reader.sv
// SPI-master poller for ADXL362-class sensors: one config write after reset,
// then repeated burst reads of N_CH 16-bit channels published with valid/ack.
module spi_burst_sensor_reader #(
  parameter int          CLK_DIV   = 4,
  parameter int          N_CH      = 3,
  parameter int          DATA_W    = 12,
  parameter logic [7:0]  BASE_ADDR = 8'h0E,
  parameter logic [7:0]  CFG_ADDR  = 8'h2D,
  parameter logic [7:0]  CFG_DATA  = 8'h02,
  parameter int          IDLE_CYC  = 16
) (
  input  logic                     clk_SPI,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     MISO,
  output logic                     SCLK,
  output logic                     MOSI,
  output logic                     n_CS,
  output logic [N_CH*DATA_W-1:0]   samples,
  output logic                     sample_valid,
  input  logic                     sample_ack,
  output logic                     overrun,
  output logic                     cfg_done,
  output logic                     busy
);

  localparam int TXW = 16 + 16 * N_CH;
  localparam int RXW = 16 * N_CH;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(IDLE_CYC - 1);
  localparam logic [7:0]  LAST_RD  = 8'(TXW - 1);
  localparam logic [7:0]  LAST_CFG = 8'd23;
  localparam logic [TXW-1:0] CFG_HDR =
    {8'h0A, CFG_ADDR, CFG_DATA, {(TXW-24){1'b0}}};
  localparam logic [TXW-1:0] RD_HDR =
    {8'h0B, BASE_ADDR, {(TXW-16){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t r_state, w_next;

  logic [15:0]            r_cnt;
  logic [7:0]             r_bit;
  logic [TXW-1:0]         r_tx;
  logic [RXW-1:0]         r_rx;
  logic                   r_sclk;
  logic                   r_cfg_done;
  logic                   r_valid;
  logic                   r_ovr;
  logic [N_CH*DATA_W-1:0] r_samples;

  logic                   w_tick;
  logic                   w_last;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_round_done;
  logic                   w_load;
  logic [N_CH*DATA_W-1:0] w_round;
  logic                   w_unused_ok;

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    w_last = (r_bit == (r_cfg_done ? LAST_RD : LAST_CFG));
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_START;
      end
      S_START: begin
        w_tick = (r_cnt == DIV_M1);
        if (w_tick) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_tick = (r_cnt == DIV_M1);
        if (w_tick && r_sclk && w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        w_tick = (r_cnt == DIV_M1);
        if (w_tick) w_next = S_GAP;
      end
      S_GAP: begin
        w_tick = (r_cnt == GAP_M1);
        if (w_tick) w_next = enable ? S_START : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rise = w_tick && ((r_state == S_START) ||
                  (r_state == S_SHIFT && !r_sclk));
  assign w_fall = w_tick && (r_state == S_SHIFT) && r_sclk;
  assign w_round_done = w_tick && (r_state == S_HOLD) && r_cfg_done;
  assign w_load = (w_next == S_START) && (r_state != S_START);

  // byte 2k is the low byte of channel k; bytes arrive first-at-top
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_round[k*DATA_W +: DATA_W] = DATA_W'({
      r_rx[RXW-9-16*k -: 8],
      r_rx[RXW-1-16*k -: 8]});
  end

  assign w_unused_ok = ^r_rx;

  always_ff @(posedge clk_SPI) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_sclk     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
      r_samples  <= '0;
    end else begin
      r_state <= w_next;
      if (w_tick || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_tx  <= r_cfg_done ? RD_HDR : CFG_HDR;
        r_bit <= '0;
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        if (r_cfg_done && r_bit >= 8'd16)
          r_rx <= {r_rx[RXW-2:0], MISO};
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        r_tx   <= r_tx << 1;
        r_bit  <= r_bit + 1'b1;
      end

      if (w_tick && r_state == S_HOLD && !r_cfg_done)
        r_cfg_done <= 1'b1;

      // a completing round wins over a plain ack
      if (w_round_done) begin
        r_samples <= w_round;
        r_valid   <= 1'b1;
        if (r_valid && !sample_ack)
          r_ovr <= 1'b1;
        else if (sample_ack)
          r_ovr <= 1'b0;
      end else if (sample_ack) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign busy         = (r_state == S_START) ||
                        (r_state == S_SHIFT) ||
                        (r_state == S_HOLD);
  assign n_CS         = !busy;
  assign SCLK         = r_sclk;
  assign MOSI         = r_tx[TXW-1];
  assign samples      = r_samples;
  assign sample_valid = r_valid;
  assign overrun      = r_ovr;
  assign cfg_done     = r_cfg_done;

endmodule

// File: tb/tb_spi_burst_sensor_reader.sv
// Bench for spi_burst_sensor_reader: sensor model on the pins, bus monitor,
// and a queue of expected sample words matched at each round completion.
module tb_spi_burst_sensor_reader;

  localparam int CLK_DIV = 2;
  localparam int N_CH    = 3;
  localparam int DATA_W  = 12;
  localparam int PER     = 10;

  logic        clk_SPI = 1'b0;
  logic        reset;
  logic        enable;
  logic        MISO = 1'b0;
  logic        SCLK;
  logic        MOSI;
  logic        n_CS;
  logic [35:0] samples;
  logic        sample_valid;
  logic        sample_ack;
  logic        overrun;
  logic        cfg_done;
  logic        busy;

  spi_burst_sensor_reader #(
    .CLK_DIV(CLK_DIV), .N_CH(N_CH), .DATA_W(DATA_W),
    .BASE_ADDR(8'h0E), .CFG_ADDR(8'h2D), .CFG_DATA(8'h02),
    .IDLE_CYC(16)
  ) dut (
    .clk_SPI(clk_SPI), .reset(reset), .enable(enable),
    .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .n_CS(n_CS),
    .samples(samples), .sample_valid(sample_valid),
    .sample_ack(sample_ack), .overrun(overrun),
    .cfg_done(cfg_done), .busy(busy)
  );

  always #(PER/2) clk_SPI = ~clk_SPI;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] sb_q[$];
  logic [47:0] data_q[$];

  int     n_fall = 0;
  int     n_rise = 0;
  int     sclk_rises = 0;
  int     sclk_falls = 0;
  int     bad = 0;
  bit     in_txn = 0;
  bit     was_cfg = 0;
  bit     expect_cfg = 1;
  bit     abort = 0;
  time    t_fall, t_rise, t_srise, t_sfall, gap_time;
  logic [23:0] mosi_sh;
  logic [63:0] frame;
  logic [7:0]  last_cmd = 8'h00;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [47:0] d);
    logic [35:0] m;
    logic [15:0] w;
    m = '0;
    for (int k = 0; k < 3; k++) begin
      w = {d[39-16*k -: 8], d[47-16*k -: 8]};
      m[12*k +: 12] = w[11:0];
    end
    return m;
  endfunction

  function automatic int ev_val(input int which);
    case (which)
      0: return n_fall;
      1: return n_rise;
      2: return sclk_rises;
      3: return sclk_falls;
      default: return 0;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int target,
                         input string tag);
    int n;
    n = 0;
    while (ev_val(which) < target && n < 5000) begin
      @(negedge clk_SPI);
      n++;
    end
    if (n >= 5000) chk({tag, "_timeout"}, ev_val(which), target);
  endtask

  always @(negedge n_CS) begin
    logic [47:0] d;
    in_txn = 1;
    n_fall++;
    if (n_rise > 0) gap_time = $time - t_rise;
    t_fall = $time;
    was_cfg = expect_cfg;
    sclk_rises = 0;
    sclk_falls = 0;
    bad = 0;
    mosi_sh = '0;
    if (!expect_cfg) begin
      if (data_q.size() > 0) begin
        d = data_q.pop_front();
      end else begin
        d[31:0]  = $urandom;
        d[47:32] = 16'($urandom);
      end
      sb_q.push_back(model(d));
      frame = {16'h0000, d};
    end else begin
      frame = '0;
    end
    MISO = frame[63];
  end

  always @(posedge SCLK) if (in_txn) begin
    if (sclk_rises == 0) begin
      if ($time - t_fall != CLK_DIV*PER) bad++;
    end else if ($time - t_srise != 2*CLK_DIV*PER) begin
      bad++;
    end
    if (sclk_rises < 24) mosi_sh = {mosi_sh[22:0], MOSI};
    else if (MOSI) bad++;
    sclk_rises++;
    t_srise = $time;
  end

  always @(negedge SCLK) if (in_txn) begin
    if ($time - t_srise != CLK_DIV*PER) bad++;
    sclk_falls++;
    t_sfall = $time;
    frame = frame << 1;
    MISO = frame[63];
  end

  always @(posedge n_CS) if (in_txn) begin
    in_txn = 0;
    n_rise++;
    t_rise = $time;
    if (!abort && $time - t_sfall != CLK_DIV*PER) bad++;
    @(negedge clk_SPI);
    if (abort) begin
      abort = 0;
      if (!was_cfg && sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      last_cmd = mosi_sh[23:16];
      chk("timing", bad, 0);
      if (was_cfg) begin
        chk("cfg_cmd", mosi_sh[23:16], 8'h0A);
        chk("cfg_body", mosi_sh[15:0], 16'h2D02);
        chk("cfg_pulses", sclk_rises, 24);
        chk("cfg_done", cfg_done, 1);
        expect_cfg = 0;
      end else begin
        chk("rd_cmd", mosi_sh[23:16], 8'h0B);
        chk("rd_addr", mosi_sh[15:8], 8'h0E);
        chk("rd_mosi0", mosi_sh[7:0], 8'h00);
        chk("rd_pulses", sclk_rises, 64);
        chk("rd_valid", sample_valid, 1);
        if (sb_q.size() == 0) chk("sb_empty", sb_q.size(), 1);
        else chk("samples", samples, sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 0;
    enable = 0;
    sample_ack = 0;
    repeat (3) @(negedge clk_SPI);
    chk("rst_ncs", n_CS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_samples", samples, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cfg", cfg_done, 0);
    chk("rst_busy", busy, 0);

    data_q.push_back(48'h3412FF0F0008);
    reset = 1;
    enable = 1;
    wait_ev(1, 1, "cfg");
    wait_ev(0, 2, "rd1_start");
    chk("gap", gap_time, 16*PER);
    wait_ev(1, 2, "rd1");
    @(negedge clk_SPI);
    chk("rd1_samples", samples, 36'h800FFF234);
    chk("rd1_ovr", overrun, 0);

    wait_ev(1, 3, "rd2");
    @(negedge clk_SPI);
    chk("ovr_set", overrun, 1);
    sample_ack = 1;
    @(negedge clk_SPI);
    sample_ack = 0;
    chk("ack_valid", sample_valid, 0);
    chk("ack_ovr", overrun, 0);

    wait_ev(1, 4, "rd3");
    wait_ev(0, 5, "rd4_start");
    wait_ev(3, 64, "rd4_last");
    @(negedge clk_SPI);
    sample_ack = 1;
    @(negedge clk_SPI);
    sample_ack = 0;
    chk("coin_done", n_rise, 5);
    chk("coin_valid", sample_valid, 1);
    chk("coin_ovr", overrun, 0);
    sample_ack = 1;
    @(negedge clk_SPI);
    sample_ack = 0;
    chk("coin_clr", sample_valid, 0);

    wait_ev(0, 6, "rd5_start");
    wait_ev(2, 10, "rd5_bits");
    enable = 0;
    wait_ev(1, 6, "rd5");
    repeat (100) @(negedge clk_SPI);
    chk("en_nofall", n_fall, 6);
    chk("en_busy", busy, 0);
    chk("en_ncs", n_CS, 1);
    chk("en_valid", sample_valid, 1);
    sample_ack = 1;
    @(negedge clk_SPI);
    sample_ack = 0;
    enable = 1;
    wait_ev(1, 7, "rd6");
    @(negedge clk_SPI);
    chk("en_cmd", last_cmd, 8'h0B);

    wait_ev(0, 8, "rd7_start");
    wait_ev(2, 30, "rd7_bits");
    abort = 1;
    reset = 0;
    @(negedge clk_SPI);
    chk("mid_ncs", n_CS, 1);
    chk("mid_sclk", SCLK, 0);
    chk("mid_samples", samples, 0);
    chk("mid_valid", sample_valid, 0);
    chk("mid_cfg", cfg_done, 0);
    expect_cfg = 1;
    reset = 1;
    wait_ev(1, 9, "recfg");
    @(negedge clk_SPI);
    chk("recfg_cmd", last_cmd, 8'h0A);
    wait_ev(1, 10, "rd8");
    @(negedge clk_SPI);
    chk("rd8_valid", sample_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_burst_sensor_reader.md
Name: spi_burst_sensor_reader

Overview:
- Parametrised SPI-master poller for ADXL362-class sensors, running entirely in the clk_SPI domain.
- Generates its own SCLK from clk_SPI using a divider.
- After reset it performs one configuration register write. It then repeatedly burst-reads N_CH consecutive 16-bit little-endian channel registers.
- Each completed round is published as one packed sample word with a valid/ack handshake and an overrun flag. It sits between the accelerometer pins and the memory-mapped sensor interface.

Parameters:
- CLK_DIV, 4: clk_SPI cycles per SCLK half-period; legal range 1..255.
- N_CH, 3: number of channels per burst; legal range 1..8.
- DATA_W, 12: bits kept per channel; legal range 1..16.
- BASE_ADDR, 8'h0E: address of the first channel's low byte.
- CFG_ADDR, 8'h2D: configuration register address.
- CFG_DATA, 8'h02: configuration value (measurement mode).
- IDLE_CYC, 16: clk_SPI cycles n_CS stays high between transactions; minimum 1.

Ports:
- clk_SPI, input, 1: block clock.
- reset, input, 1: synchronous, active-low.
- enable, input, 1: permits transactions to start.
- MISO, input, 1: serial data from the sensor.
- SCLK, output, 1: SPI clock, mode 0 (idles low).
- MOSI, output, 1: serial data to the sensor.
- n_CS, output, 1: chip select, active-low.
- samples, output, N_CH*DATA_W: packed result; channel k occupies [k*DATA_W +: DATA_W].
- sample_valid, output, 1: a new round is available.
- sample_ack, input, 1: consumer acknowledge.
- overrun, output, 1: sticky flag; a round completed while sample_valid was still 1.
- cfg_done, output, 1: the configuration write has completed.
- busy, output, 1: n_CS is low or a transaction is in progress.

Behaviour:
- Reset values (reset==0 at a clk_SPI edge): n_CS=1, SCLK=0, MOSI=0, samples=0, sample_valid=0, overrun=0, cfg_done=0, busy=0, FSM in IDLE.
- A reset applied mid-transaction aborts it immediately. The next transaction after reset is the configuration write.
- FSM states:
  - IDLE: waits for enable==1.
  - START: asserts n_CS=0 and drives MOSI with the first bit.
  - SHIFT: shifts bits.
  - HOLD: keeps n_CS low for CLK_DIV cycles after the last SCLK falling edge.
  - GAP: n_CS=1 for IDLE_CYC cycles.
  - IDLE→START occurs when enable==1.
  - START→SHIFT occurs after CLK_DIV cycles.
  - SHIFT→HOLD occurs after the last bit.
  - HOLD→GAP.
  - GAP→START if enable==1; otherwise GAP→IDLE.
- enable may fall at any time; the current transaction always completes.
- Configuration transaction (first after reset, cfg_done==0): 24 bits, MSB-first: 8'h0A, CFG_ADDR, CFG_DATA. cfg_done is set when this transaction's HOLD phase ends.
- Read transaction (cfg_done==1): 16+16*N_CH bits.
  - Sends 8'h0B, then BASE_ADDR.
  - Then captures 2*N_CH bytes MSB-first; MOSI=0 during the data phase.
  - Byte 2k is channel k low byte; byte 2k+1 is channel k high byte.
  - Channel value = {hi,lo}[DATA_W-1:0].
- SPI timing:
  - Each bit lasts 2*CLK_DIV cycles.
  - MOSI updates on SCLK falling edges (the first bit updates at START).
  - MISO is sampled in the clk_SPI cycle in which SCLK rises.
  - SCLK stays low outside SHIFT and ends low.
- Results staging: captured bytes go to an internal staging register. samples is untouched until the whole round has completed.
- Round completion: in the cycle HOLD exits to GAP:
  - samples loads the staging register.
  - sample_valid becomes 1.
  - if sample_valid was already 1 and no ack arrived in that cycle, overrun becomes 1; the new data still overwrites samples.
- Handshake:
  - sample_valid stays 1 until sample_ack==1 is seen; it clears on the next edge.
  - sample_ack clears overrun on the same edge.
  - If completion and ack coincide, sample_valid stays 1 and overrun is not set.
  - sample_ack while sample_valid==0 has no effect.
- busy = 1 in START, SHIFT and HOLD.

Test Plan:
- Configuration write: CLK_DIV=2, reset released, enable=1 → exactly 24 SCLK pulses, each 4 cycles long; MOSI stream 0x0A,0x2D,0x02; n_CS then high for 16 cycles; cfg_done=1.
- Read round: N_CH=3, DATA_W=12; sensor model returns 0x34,0x12,0xFF,0x0F,0x00,0x08 → samples = {12'h800,12'hFFF,12'h234}; sample_valid=1 in the cycle n_CS rises; 64 SCLK pulses seen; address byte = 0x0E.
- Overrun: never assert sample_ack across two rounds → overrun=1 after the second round and samples holds the second data; one sample_ack → sample_valid=0 and overrun=0 on the next edge.
- Coincident ack: sample_ack asserted in the exact completion cycle → sample_valid stays 1, overrun stays 0.
- Enable drop: enable→0 mid-read → the read finishes (all 64 pulses), samples update, the FSM reaches IDLE, and n_CS stays high thereafter; enable→1 → the next transaction is a read, not a configuration write.
- Reset mid-read: reset=0 during bit 30 → n_CS=1, SCLK=0, and samples=0 on the next edge; after release, the first transaction is again the 0x0A configuration write.
